// File: rtl/rv_seq_ctrl_if.sv
// Handshake and strobe bundle between the RV sequencer and its datapath/memories.
// master = sequencer side, slave = datapath/memory side.
interface rv_seq_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             instr_valid;
   logic             mem_ready;
   logic             is_load;
   logic             is_store;
   logic             is_branch;
   logic             is_jump;
   logic             is_ecall;
   logic             branch_taken;
   logic             instr_req;
   logic             instr_load;
   logic             rf_read_en;
   logic             alu_en;
   logic             mem_req;
   logic             mem_we;
   logic             rf_write_en;
   logic             pc_en;
   logic             pc_sel;
   logic             halted;
   logic             err;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   modport master (
      input  instr_valid, mem_ready, is_load, is_store, is_branch, is_jump, is_ecall, branch_taken,
      output instr_req, instr_load, rf_read_en, alu_en, mem_req, mem_we, rf_write_en,
             pc_en, pc_sel, halted, err, state, instret
   );

   modport slave (
      output instr_valid, mem_ready, is_load, is_store, is_branch, is_jump, is_ecall, branch_taken,
      input  instr_req, instr_load, rf_read_en, alu_en, mem_req, mem_we, rf_write_en,
             pc_en, pc_sel, halted, err, state, instret
   );
endinterface

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV core datapath.
// Halts on ECALL, counts retired instructions and traps bus timeouts in a sticky error state.
module rv_seq_ctrl #(
   parameter int FETCH_TIMEOUT = 16,
   parameter int MEM_TIMEOUT   = 16,
   parameter int CNT_W         = 32
) (
   input  logic          clk,
   input  logic          rst,
   rv_seq_ctrl_if.master bus
);
   localparam int MAX_TO = (FETCH_TIMEOUT > MEM_TIMEOUT) ? FETCH_TIMEOUT : MEM_TIMEOUT;
   localparam int WAIT_W = $clog2(MAX_TO);
   localparam logic [WAIT_W-1:0] FETCH_LAST = WAIT_W'(FETCH_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] MEM_LAST   = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_ERR    = 3'd7
   } state_e;

   typedef struct packed {
      logic ld;
      logic st;
      logic br;
      logic jmp;
   } cls_t;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   cls_t              cls_q, cls_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              wait_inc;
   logic              instr_req, instr_load, rf_read_en, alu_en, mem_req, mem_we;
   logic              rf_write_en, pc_en, pc_sel, halted, err;

   // Next-state selection and strobe decode; instr_load and pc_sel follow live inputs
   always_comb begin
      state_d     = state_q;
      cls_d       = cls_q;
      wait_inc    = 1'b0;
      instr_req   = 1'b0;
      instr_load  = 1'b0;
      rf_read_en  = 1'b0;
      alu_en      = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      rf_write_en = 1'b0;
      pc_en       = 1'b0;
      pc_sel      = 1'b0;
      halted      = 1'b0;
      err         = 1'b0;
      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            instr_req  = 1'b1;
            instr_load = bus.instr_valid;
            if (bus.instr_valid) begin
               state_d = ST_DECODE;
            end else if (wait_q == FETCH_LAST) begin
               state_d = ST_ERR;
            end else begin
               wait_inc = 1'b1;
            end
         end
         ST_DECODE: begin
            rf_read_en = 1'b1;
            cls_d      = {bus.is_load, bus.is_store, bus.is_branch, bus.is_jump};
            if (bus.is_ecall) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_en = 1'b1;
            if (cls_q.ld || cls_q.st) begin
               state_d = ST_MEM;
            end else if (cls_q.br) begin
               pc_en   = 1'b1;
               pc_sel  = bus.branch_taken;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = cls_q.st;
            // A load latch takes precedence so a malformed decode still writes back once
            if (bus.mem_ready) begin
               if (cls_q.ld) begin
                  state_d = ST_WB;
               end else begin
                  pc_en   = 1'b1;
                  state_d = ST_FETCH;
               end
            end else if (wait_q == MEM_LAST) begin
               state_d = ST_ERR;
            end else begin
               wait_inc = 1'b1;
            end
         end
         ST_WB: begin
            rf_write_en = 1'b1;
            pc_en       = 1'b1;
            pc_sel      = cls_q.jmp;
            state_d     = ST_FETCH;
         end
         ST_HALT: halted = 1'b1;
         ST_ERR:  err    = 1'b1;
         default: state_d = ST_ERR;
      endcase

      if (wait_inc) begin
         wait_d = wait_q + WAIT_ONE;
      end else begin
         wait_d = '0;
      end

      if (pc_en) begin
         instret_d = instret_q + CNT_ONE;
      end else begin
         instret_d = instret_q;
      end
   end

   // State, wait counter, class latches and retired-instruction counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RESET;
         wait_q    <= '0;
         cls_q     <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         cls_q     <= cls_d;
         instret_q <= instret_d;
      end
   end

   assign bus.instr_req   = instr_req;
   assign bus.instr_load  = instr_load;
   assign bus.rf_read_en  = rf_read_en;
   assign bus.alu_en      = alu_en;
   assign bus.mem_req     = mem_req;
   assign bus.mem_we      = mem_we;
   assign bus.rf_write_en = rf_write_en;
   assign bus.pc_en       = pc_en;
   assign bus.pc_sel      = pc_sel;
   assign bus.halted      = halted;
   assign bus.err         = err;
   assign bus.state       = state_q;
   assign bus.instret     = instret_q;
endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Self-checking bench for rv_seq_ctrl: hand table of instructions, random instruction stream
// against a per-instruction trace model, and reset/halt/timeout corner sequences.
module tb_rv_seq_ctrl;
   localparam int FT = 16;
   localparam int MT = 16;

   localparam int C_ALU    = 0;
   localparam int C_LOAD   = 1;
   localparam int C_STORE  = 2;
   localparam int C_BRANCH = 3;
   localparam int C_JUMP   = 4;
   localparam int C_ECALL  = 5;
   localparam int C_FTO    = 6;
   localparam int C_MTO    = 7;

   localparam logic [10:0] O_IREQ = 11'h400;
   localparam logic [10:0] O_ILD  = 11'h200;
   localparam logic [10:0] O_RRD  = 11'h100;
   localparam logic [10:0] O_ALU  = 11'h080;
   localparam logic [10:0] O_MREQ = 11'h040;
   localparam logic [10:0] O_MWE  = 11'h020;
   localparam logic [10:0] O_RFW  = 11'h010;
   localparam logic [10:0] O_PCE  = 11'h008;
   localparam logic [10:0] O_PCS  = 11'h004;
   localparam logic [10:0] O_HLT  = 11'h002;
   localparam logic [10:0] O_ERR  = 11'h001;
   localparam logic [10:0] O_NONE = 11'h000;

   logic clk;
   logic rst;
   rv_seq_ctrl_if #(.CNT_W(32)) bus ();

   rv_seq_ctrl #(.FETCH_TIMEOUT(FT), .MEM_TIMEOUT(MT), .CNT_W(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  st;
      logic [10:0] s;
      logic        iv;
      logic        mr;
      logic [4:0]  dec;
      logic        tk;
   } cyc_t;

   typedef struct {
      int   cls;
      int   fw;
      int   mw;
      bit   tk;
      int   exp_len;
      int   exp_rfw;
      bit   exp_pcs;
      int   exp_mreq;
      int   exp_mwe;
   } vec_t;

   cyc_t        seq[$];
   vec_t        tbl[8];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model_instret;
   int          obs_len, obs_rfw, obs_mreq, obs_mwe;
   bit          obs_pcs, obs_seen;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(1, 0));
   endfunction

   function automatic logic [4:0] rd5();
      return 5'($urandom_range(31, 0));
   endfunction

   function automatic logic [10:0] outs();
      return {bus.instr_req, bus.instr_load, bus.rf_read_en, bus.alu_en, bus.mem_req, bus.mem_we,
              bus.rf_write_en, bus.pc_en, bus.pc_sel, bus.halted, bus.err};
   endfunction

   // decoder one-hot {load, store, branch, jump, ecall}
   function automatic logic [4:0] dec_of(input int cls);
      case (cls)
         C_LOAD, C_MTO: return 5'b10000;
         C_STORE:       return 5'b01000;
         C_BRANCH:      return 5'b00100;
         C_JUMP:        return 5'b00010;
         C_ECALL:       return 5'b00001;
         default:       return 5'b00000;
      endcase
   endfunction

   task automatic push(input logic [2:0] st, input logic [10:0] s, input logic iv, input logic mr,
                       input logic [4:0] dec, input logic tk);
      cyc_t c;
      c.st = st; c.s = s; c.iv = iv; c.mr = mr; c.dec = dec; c.tk = tk;
      seq.push_back(c);
   endtask

   // Expected per-cycle trace of one instruction: fw fetch waits, mw memory waits,
   // tail = cycles spent observing HALT/ERR afterwards. Inputs not sampled are noise.
   task automatic build(input int cls, input int fw, input int mw, input bit tk, input int tail);
      int mcnt;
      bit is_mem, is_st;
      seq.delete();
      if (cls == C_FTO) begin
         for (int i = 0; i < FT; i++) push(3'd1, O_IREQ, 1'b0, rb(), rd5(), rb());
         for (int i = 0; i < tail; i++) push(3'd7, O_ERR, rb(), rb(), rd5(), rb());
         return;
      end
      for (int i = 0; i < fw; i++) push(3'd1, O_IREQ, 1'b0, rb(), rd5(), rb());
      push(3'd1, O_IREQ | O_ILD, 1'b1, rb(), rd5(), rb());
      push(3'd2, O_RRD, rb(), rb(), dec_of(cls), rb());
      if (cls == C_ECALL) begin
         for (int i = 0; i < tail; i++) push(3'd6, O_HLT, rb(), rb(), rd5(), rb());
         return;
      end
      if (cls == C_BRANCH) push(3'd3, O_ALU | O_PCE | (tk ? O_PCS : O_NONE), rb(), rb(), rd5(), tk);
      else                 push(3'd3, O_ALU, rb(), rb(), rd5(), rb());
      is_mem = (cls == C_LOAD) || (cls == C_STORE) || (cls == C_MTO);
      is_st  = (cls == C_STORE);
      if (is_mem) begin
         mcnt = (cls == C_MTO) ? MT : mw;
         for (int i = 0; i < mcnt; i++) push(3'd4, O_MREQ | (is_st ? O_MWE : O_NONE), rb(), 1'b0, rd5(), rb());
         if (cls == C_MTO) begin
            for (int i = 0; i < tail; i++) push(3'd7, O_ERR, rb(), rb(), rd5(), rb());
            return;
         end
         push(3'd4, O_MREQ | (is_st ? (O_MWE | O_PCE) : O_NONE), rb(), 1'b1, rd5(), rb());
      end
      if (cls == C_ALU || cls == C_LOAD || cls == C_JUMP)
         push(3'd5, O_RFW | O_PCE | ((cls == C_JUMP) ? O_PCS : O_NONE), rb(), rb(), rd5(), rb());
   endtask

   // Drive up to limit trace cycles, compare every cycle and tally what the DUT showed
   task automatic play(input int limit);
      logic [10:0] mask;
      obs_len = 0; obs_rfw = 0; obs_mreq = 0; obs_mwe = 0; obs_pcs = 1'b0; obs_seen = 1'b0;
      for (int i = 0; i < seq.size() && i < limit; i++) begin
         bus.instr_valid  = seq[i].iv;
         bus.mem_ready    = seq[i].mr;
         bus.is_load      = seq[i].dec[4];
         bus.is_store     = seq[i].dec[3];
         bus.is_branch    = seq[i].dec[2];
         bus.is_jump      = seq[i].dec[1];
         bus.is_ecall     = seq[i].dec[0];
         bus.branch_taken = seq[i].tk;
         #2;
         mask = ((seq[i].s & O_PCE) != O_NONE) ? 11'h7FF : ~O_PCS;
         check("state", 32'(bus.state), 32'(seq[i].st));
         check("strobes", 32'(outs() & mask), 32'(seq[i].s & mask));
         check("instret", bus.instret, model_instret);
         obs_rfw  += int'(bus.rf_write_en);
         obs_mreq += int'(bus.mem_req);
         obs_mwe  += int'(bus.mem_we);
         if (bus.pc_en && !obs_seen) begin
            obs_seen = 1'b1;
            obs_len  = i + 1;
            obs_pcs  = bus.pc_sel;
         end
         if ((seq[i].s & O_PCE) != O_NONE) model_instret = model_instret + 32'd1;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.instr_valid = 1'b0; bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
      bus.is_load = 1'b0; bus.is_store = 1'b0; bus.is_branch = 1'b0; bus.is_jump = 1'b0; bus.is_ecall = 1'b0;
      #1;
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_outputs", 32'(outs()), 32'd0);
      check("rst_instret", bus.instret, 32'd0);
      model_instret = 32'd0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("release_state", 32'(bus.state), 32'd0);
      @(posedge clk);
      #1;
      check("first_fetch_state", 32'(bus.state), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int rc, rf, rm;
      bit rt;
      //            cls       fw mw tk    len rfw pcs  mreq mwe
      tbl[0] = '{C_ALU,    0, 0, 1'b0, 4,  1,  1'b0, 0,   0};
      tbl[1] = '{C_LOAD,   0, 3, 1'b0, 8,  1,  1'b0, 4,   0};
      tbl[2] = '{C_STORE,  0, 0, 1'b0, 4,  0,  1'b0, 1,   1};
      tbl[3] = '{C_BRANCH, 0, 0, 1'b1, 3,  0,  1'b1, 0,   0};
      tbl[4] = '{C_BRANCH, 0, 0, 1'b0, 3,  0,  1'b0, 0,   0};
      tbl[5] = '{C_JUMP,   0, 0, 1'b0, 4,  1,  1'b1, 0,   0};
      tbl[6] = '{C_ALU,    2, 0, 1'b0, 6,  1,  1'b0, 0,   0};
      tbl[7] = '{C_LOAD,   0, 0, 1'b0, 5,  1,  1'b0, 1,   0};

      rst = 1'b0;
      bus.instr_valid = 1'b0; bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
      bus.is_load = 1'b0; bus.is_store = 1'b0; bus.is_branch = 1'b0; bus.is_jump = 1'b0; bus.is_ecall = 1'b0;
      model_instret = 32'd0;
      @(posedge clk);
      #1;
      do_reset();

      for (int k = 0; k < 8; k++) begin
         build(tbl[k].cls, tbl[k].fw, tbl[k].mw, tbl[k].tk, 0);
         play(1000);
         check("tbl_len", 32'(obs_len), 32'(tbl[k].exp_len));
         check("tbl_rf_write", 32'(obs_rfw), 32'(tbl[k].exp_rfw));
         check("tbl_pc_sel", 32'(obs_pcs), 32'(tbl[k].exp_pcs));
         check("tbl_mem_req", 32'(obs_mreq), 32'(tbl[k].exp_mreq));
         check("tbl_mem_we", 32'(obs_mwe), 32'(tbl[k].exp_mwe));
      end
      check("tbl_instret", bus.instret, 32'd8);

      for (int n = 0; n < 150; n++) begin
         rc = int'($urandom_range(4, 0));
         rf = int'($urandom_range(4, 0));
         rm = int'($urandom_range(4, 0));
         rt = rb();
         build(rc, rf, rm, rt, 0);
         play(1000);
      end

      // valid/ready arriving on the final allowed cycle must win over the timeout
      build(C_LOAD, FT - 1, MT - 1, 1'b0, 0);
      play(1000);
      check("boundary_no_err", 32'(bus.err), 32'd0);
      check("boundary_back_to_fetch", 32'(bus.state), 32'd1);

      // abort a load in its third MEM cycle
      build(C_LOAD, 0, 5, 1'b0, 0);
      play(5);
      check("mid_mem_state", 32'(bus.state), 32'd4);
      do_reset();

      build(C_ECALL, 0, 0, 1'b0, 20);
      play(1000);
      check("halt_instret", bus.instret, 32'd0);
      do_reset();

      build(C_FTO, 0, 0, 1'b0, 5);
      play(1000);
      do_reset();

      build(C_MTO, 0, 0, 1'b0, 5);
      play(1000);
      check("mem_timeout_err", 32'(bus.err), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
